// File: rtl/uart_tx_ctrl_pkg.sv
// Shared UART definitions: the 3-bit FSM state encoding and the default payload width.
// The RX side imports the same package, so both ends agree on the encoding.
package uart_tx_ctrl_pkg;

   localparam int UART_DATA_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } uart_state_t;

endpackage

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: frames a latched payload as start, data (LSB first), optional parity and stop bits.
// Parity comes from an external generator that watches store and par_typ_q.
module uart_tx_ctrl
   import uart_tx_ctrl_pkg::*;
#(
   parameter int DATA_WIDTH = UART_DATA_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  par_bit,
   output logic [DATA_WIDTH-1:0] store,
   output logic                  par_typ_q,
   output logic                  busy,
   output logic                  TX_OUT
);

   localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   uart_state_t   state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          par_en_q;

   assign cnt_nxt = cnt + 1'b1;

   // TX_OUT and busy are registered with the value of the state being entered,
   // so each bit appears on the line for exactly the cycle its state is held.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= IDLE;
         TX_OUT    <= 1'b1;
         busy      <= 1'b0;
         store     <= '0;
         par_typ_q <= 1'b0;
         par_en_q  <= 1'b0;
         cnt       <= '0;
      end else begin
         case (state)
            IDLE, STOP: begin
               if (Data_Valid) begin
                  store     <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  state     <= START;
                  TX_OUT    <= 1'b0;
                  busy      <= 1'b1;
               end else begin
                  state  <= IDLE;
                  TX_OUT <= 1'b1;
                  busy   <= 1'b0;
               end
            end
            START: begin
               state  <= DATA;
               cnt    <= '0;
               TX_OUT <= store[0];
               busy   <= 1'b1;
            end
            DATA: begin
               busy <= 1'b1;
               if (cnt == LAST) begin
                  cnt <= '0;
                  if (par_en_q) begin
                     state  <= PARITY;
                     TX_OUT <= par_bit;
                  end else begin
                     state  <= STOP;
                     TX_OUT <= 1'b1;
                  end
               end else begin
                  cnt    <= cnt_nxt;
                  TX_OUT <= store[cnt_nxt];
               end
            end
            PARITY: begin
               state  <= STOP;
               TX_OUT <= 1'b1;
               busy   <= 1'b1;
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               busy   <= 1'b0;
               cnt    <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: reset, plain/even/odd frames, back-to-back frames,
// mid-frame input changes and mid-frame reset, with hand-computed line sequences.
module tb_uart_tx_ctrl;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       par_bit;
   logic [7:0] store;
   logic       par_typ_q;
   logic       busy;
   logic       TX_OUT;

   int checks = 0;
   int errors = 0;

   uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .par_bit    (par_bit),
      .store      (store),
      .par_typ_q  (par_typ_q),
      .busy       (busy),
      .TX_OUT     (TX_OUT)
   );

   // External parity generator model: even parity when par_typ_q=0, odd when 1.
   assign par_bit = (^store) ^ par_typ_q;

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_idle(input string tag);
      check({tag, ".tx"}, 32'(TX_OUT), 32'd1);
      check({tag, ".busy"}, 32'(busy), 32'd0);
   endtask

   task automatic accept(input logic [7:0] d, input logic pe, input logic pt);
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      Data_Valid = 1'b1;
      tick();
      Data_Valid = 1'b0;
   endtask

   // Walks one frame from its start-bit cycle; bit i of exp is the i-th line bit.
   task automatic frame(input string tag, input logic [15:0] exp, input int n,
                        input logic [7:0] d, input logic pt, input logic pe,
                        input bit disturb, input bit chain, input logic [7:0] nd);
      logic [15:0] e;
      e = exp;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s.tx[%0d]", tag, i), 32'(TX_OUT), 32'(e[i]));
         check($sformatf("%s.busy[%0d]", tag, i), 32'(busy), 32'd1);
         check($sformatf("%s.store[%0d]", tag, i), 32'(store), 32'(d));
         check($sformatf("%s.ptq[%0d]", tag, i), 32'(par_typ_q), 32'(pt));
         if (disturb && i < n - 1) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
            PAR_EN     = ~pe;
            PAR_TYP    = ~pt;
         end else if (chain && i == n - 1) begin
            Data_Valid = 1'b1;
            P_DATA     = nd;
            PAR_EN     = 1'b0;
            PAR_TYP    = 1'b0;
         end else begin
            Data_Valid = 1'b0;
         end
         tick();
         Data_Valid = 1'b0;
      end
      if (!chain) check_idle({tag, ".end"});
   endtask

   initial begin
      RST        = 1'b1;
      Data_Valid = 1'b1;
      P_DATA     = 8'h5A;
      PAR_EN     = 1'b1;
      PAR_TYP    = 1'b1;

      // Reset held two cycles with a competing request
      for (int i = 0; i < 2; i++) begin
         tick();
         check_idle($sformatf("rst%0d", i));
         check($sformatf("rst%0d.store", i), 32'(store), 32'h00);
         check($sformatf("rst%0d.ptq", i), 32'(par_typ_q), 32'd0);
      end
      RST        = 1'b0;
      Data_Valid = 1'b0;
      tick();
      check_idle("post_rst");
      tick();
      check_idle("post_rst2");

      // 0xA5 without parity: 0,1,0,1,0,0,1,0,1,1
      accept(8'hA5, 1'b0, 1'b0);
      frame("nopar", 16'h034A, 10, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // 0xA5 even parity: 0,1,0,1,0,0,1,0,1,0,1
      accept(8'hA5, 1'b1, 1'b0);
      frame("even", 16'h054A, 11, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);

      // 0x01 odd parity: 0,1,0,0,0,0,0,0,0,0,1
      accept(8'h01, 1'b1, 1'b1);
      frame("odd", 16'h0402, 11, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

      // Back-to-back: 0xA5 then 0x3C requested during STOP
      accept(8'hA5, 1'b0, 1'b0);
      frame("b2b_a", 16'h034A, 10, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
      frame("b2b_b", 16'h0278, 10, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      // Mid-frame requests and control changes must not disturb the frame
      accept(8'hA5, 1'b0, 1'b0);
      frame("disturb", 16'h034A, 10, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);

      // Reset at data bit 3 aborts the frame
      accept(8'hA5, 1'b0, 1'b0);
      check("abort.start", 32'(TX_OUT), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      check("abort.bit3", 32'(TX_OUT), 32'd0);
      check("abort.busy3", 32'(busy), 32'd1);
      RST = 1'b1;
      tick();
      RST = 1'b0;
      check_idle("abort");
      check("abort.store", 32'(store), 32'h00);
      for (int i = 0; i < 12; i++) begin
         tick();
         check_idle($sformatf("abort_hold%0d", i));
      end

      // A fresh frame after the abort runs normally
      accept(8'h3C, 1'b0, 1'b0);
      frame("after", 16'h0278, 10, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the payload width in bits.
REQ-002 The block SHALL have port CLK, input, 1, the TX clock, one edge per transmitted bit.
REQ-003 The block SHALL have port RST, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port P_DATA, input, DATA_WIDTH, the parallel payload.
REQ-005 The block SHALL have port Data_Valid, input, 1, a one-cycle request to send P_DATA.
REQ-006 The block SHALL have port PAR_EN, input, 1, which inserts a parity bit when 1.
REQ-007 The block SHALL have port PAR_TYP, input, 1, selecting even parity when 0 and odd parity when 1.
REQ-008 The block SHALL have port par_bit, input, 1, the parity result returned by the external parity generator.
REQ-009 The block SHALL have port store, output, DATA_WIDTH, the latched payload driven to the parity generator.
REQ-010 The block SHALL have port par_typ_q, output, 1, the latched PAR_TYP driven to the parity generator.
REQ-011 The block SHALL have port busy, output, 1, high while a frame is on the line.
REQ-012 The block SHALL have port TX_OUT, output, 1, the serial line, which idles high.

Function
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; all outputs SHALL be registered.
REQ-014 In IDLE or STOP, if Data_Valid=1 at an edge, the block SHALL latch P_DATA into store and PAR_EN/PAR_TYP into internal and par_typ_q registers, then enter START.
REQ-015 In IDLE or STOP, if Data_Valid=0 at an edge, the block SHALL enter or stay in IDLE.
REQ-016 Data_Valid SHALL be ignored in START, DATA and PARITY; store and the latched parity controls SHALL stay frozen there.
REQ-017 Latency: after acceptance at edge k, TX_OUT SHALL be 0 (start bit) and busy SHALL be 1 from edge k+1.
REQ-018 START SHALL last exactly one cycle, then go to DATA with the bit counter at 0.
REQ-019 DATA SHALL drive TX_OUT = store[cnt], LSB first, for one cycle per bit over DATA_WIDTH cycles.
REQ-020 The bit counter SHALL be $clog2(DATA_WIDTH) bits wide, increment by one per DATA cycle, and clear to 0 (no wrap) on leaving DATA.
REQ-021 After bit DATA_WIDTH-1, the FSM SHALL go to PARITY if latched PAR_EN=1, else to STOP.
REQ-022 PARITY SHALL drive TX_OUT = par_bit for one cycle and then go to STOP.
REQ-023 STOP SHALL drive TX_OUT=1 with busy=1 for one cycle.
REQ-024 From STOP, busy SHALL go to 0 in IDLE, or stay 1 in START for back-to-back frames with no idle gap.
REQ-025 Frame length SHALL be DATA_WIDTH+2 cycles without parity and DATA_WIDTH+3 cycles with parity.
REQ-026 In IDLE, TX_OUT SHALL be 1 and busy SHALL be 0.
REQ-027 Unreachable state encodings SHALL return to IDLE on the next edge.
REQ-028 A change on PAR_EN, PAR_TYP or P_DATA mid-frame SHALL have no effect on the current frame.

Reset
REQ-029 While RST=1 at an edge, the block SHALL force state IDLE, TX_OUT=1, busy=0, store=0, par_typ_q=0, latched PAR_EN=0 and counter=0.
REQ-030 RST SHALL take priority over Data_Valid at the same edge.
REQ-031 RST asserted mid-frame SHALL abort the frame; the line SHALL be high from the next edge and no partial frame SHALL resume.

Structure
REQ-032 A shared UART package SHALL hold the state encoding (3-bit) and the DATA_WIDTH default, for reuse by the RX side.
REQ-033 The FSM and bit counter SHALL be written in this module; the bit-select mux SHALL be inline.
REQ-034 Parity calculation SHALL remain in the existing external parity generator, driven by store and par_typ_q; no sub-module SHALL be instantiated here.

Verification
REQ-035 Reset scenario: RST=1 for 2 cycles, with Data_Valid=1 in the same cycle -> TX_OUT=1, busy=0 and store=0x00, and no frame starts.
REQ-036 No-parity scenario: PAR_EN=0, P_DATA=0xA5, one-cycle Data_Valid -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,1 and busy high for exactly 10 cycles.
REQ-037 Even-parity scenario: PAR_EN=1, PAR_TYP=0, P_DATA=0xA5 with the model par_bit=0 -> sequence 0,1,0,1,0,0,1,0,1,0,1 and busy high for 11 cycles.
REQ-038 Odd-parity scenario: PAR_TYP=1, P_DATA=0x01 with par_bit=0 -> the parity slot is 0 and par_typ_q=1 throughout.
REQ-039 Back-to-back scenario: Data_Valid pulsed during the STOP cycle with 0x3C -> START follows STOP immediately and busy never drops.
REQ-040 Mid-frame scenario: Data_Valid=1 and P_DATA=0xFF during DATA -> the current frame is unchanged; RST at data bit 3 -> TX_OUT=1 and busy=0 on the next edge.
